// File: rtl/ram_sync_burst_ctrl.sv
// Command-driven controller in front of a single-port synchronous-read RAM.
// Accepts single-word writes and wrapping read bursts streamed on a valid/ready port.
module ram_sync_burst_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [AWIDTH:0] LEN_ONE = (AWIDTH + 1)'(1);

    state_t            state, state_next;
    logic [AWIDTH-1:0] ptr, ptr_next;
    logic [AWIDTH:0]   remaining, remaining_next;
    logic              cmd_fire;
    logic              out_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign out_fire = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            remaining <= remaining_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (cmd_fire && !cmd_write && cmd_len != '0) begin
                    state_next     = STREAM;
                    ptr_next       = cmd_addr;
                    remaining_next = cmd_len;
                end
            end
            STREAM: begin
                if (out_fire) begin
                    ptr_next       = ptr + 1'b1;
                    remaining_next = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The RAM address runs one word ahead on fire, so the next word is ready without a bubble.
    always_comb begin
        cmd_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cmd_addr;
        ram_din   = cmd_wdata;
        if (!reset) begin
            case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    ram_we    = cmd_valid && cmd_write;
                end
                STREAM: begin
                    out_valid = 1'b1;
                    busy      = 1'b1;
                    out_last  = (remaining == LEN_ONE);
                    ram_addr  = out_ready ? ptr + 1'b1 : ptr;
                end
                default: ;
            endcase
        end
    end

    assign out_data = ram_dout;

endmodule

// File: tb/tb_ram_sync_burst_ctrl.sv
// Bench for ram_sync_burst_ctrl: behavioural RAM, memory/queue reference model,
// directed scenarios followed by randomized commands and backpressure.
module tb_ram_sync_burst_ctrl;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    ram_sync_burst_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_wdata (cmd_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    // Synchronous-read RAM: dout reflects the address latched at the previous edge.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_q;
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        addr_q <= ram_addr;
    end
    assign ram_dout = mem[addr_q];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            checks     = 0;
    int            failures   = 0;
    int            ready_mode = 0;
    int            pat_idx    = 0;
    int            popped     = 0;
    bit            accepted   = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    word_t         exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: choose out_ready, compare at the falling edge, update the model.
    task automatic cycle();
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (pat_idx % 3) == 0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        pat_idx++;
        @(negedge clock);
        if (reset) begin
            check("rst_cmd_ready", cmd_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_last", out_last, 0);
            check("rst_busy", busy, 0);
            check("rst_ram_we", ram_we, 0);
            exp_q.delete();
        end else begin
            check("cmd_ready", cmd_ready, exp_q.size() == 0);
            check("busy", busy, exp_q.size() != 0);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("ram_we", ram_we, exp_q.size() == 0 && cmd_valid && cmd_write);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_last", out_last, exp_q[0].last);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end else if (cmd_valid) begin
                accepted = 1;
                if (cmd_write) begin
                    ref_mem[cmd_addr] = cmd_wdata;
                end else begin
                    for (int i = 0; i < int'(cmd_len); i++) begin
                        exp_q.push_back('{data: ref_mem[(int'(cmd_addr) + i) % DEPTH],
                                          last: (i == int'(cmd_len) - 1)});
                    end
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit wr, input int addr, input int len, input logic [DW-1:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW + 1)'(len);
        cmd_wdata = wdata;
        accepted  = 0;
        for (int n = 0; n < 200 && !accepted; n++) cycle();
        cmd_valid = 1'b0;
        check("cmd_accept", accepted, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) cycle();
        check("drain_done", exp_q.size() == 0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int n = 0; n < 3; n++) cycle();
        reset = 1'b0;
        cycle();

        // 1: preload 0xA0+i, full in-order burst at full throughput
        ready_mode = 0;
        for (int i = 0; i < DEPTH; i++) send(1, i, 0, DW'(32'hA0 + i));
        send(0, 0, 8, '0);
        drain();

        // 2: wrapping burst from addr 6
        send(0, 6, 4, '0);
        drain();

        // 3: same burst under 1,0,0 backpressure
        ready_mode = 1;
        pat_idx    = 0;
        send(0, 6, 4, '0);
        drain();
        ready_mode = 0;

        // 4: write at edge k, read the same word fired at edge k+1
        send(1, 3, 0, 32'h55);
        send(0, 3, 1, '0);
        drain();

        // 5: zero-length read is a no-op, then a full wrapping burst
        send(0, 5, 0, '0);
        cycle();
        cycle();
        send(0, 5, 8, '0);
        drain();

        // 6: reset after the second word, then a re-read of the whole RAM
        send(0, 2, 8, '0);
        popped = 0;
        for (int n = 0; n < 20 && popped < 2; n++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        send(0, 0, 8, '0);
        drain();

        // Randomized commands with random backpressure; commands queue up behind bursts
        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                send(1, int'($urandom_range(0, DEPTH - 1)), 0, DW'($urandom));
            else
                send(0, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), DW'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
